rv64_regfile_alu: RTL and testbench

- Integer datapath core of the single-cycle RV64 NPC: a 32-entry x 64-bit general-purpose register file plus a combinational 64-bit ALU.
- The decode/execute stage does three things:
  - drives register read/write addresses;
  - selects ALU operands (register data, immediates, pc);
  - picks the ALU result to write back or to use for branch/memory address.
- Operand and result selection is outside this block.

---
 rtl/rv64_regfile_alu_if.sv | 44 ++++
 rtl/rv64_regfile_alu.sv | 90 +++++++++
 tb/tb_rv64_regfile_alu.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv64_regfile_alu_if.sv
// Register-file and ALU bus of rv64_regfile_alu: write strobe, three read ports,
// ALU operands and all ALU results. The core is the slave; the decode stage is the master.
interface rv64_regfile_alu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  // No valid/ready: wen is a single-cycle write strobe sampled on the rising clock
  // edge, and every read port and ALU output is a continuous combinational function.
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [ADDR_WIDTH-1:0] raddr3;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic [DATA_WIDTH-1:0] rdata3;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] sum;
  logic                  ltu;
  logic [DATA_WIDTH-1:0] srl;
  logic [DATA_WIDTH-1:0] sra;
  logic [DATA_WIDTH-1:0] sll;
  logic [DATA_WIDTH-1:0] and_o;
  logic [DATA_WIDTH-1:0] or_o;
  logic [DATA_WIDTH-1:0] xor_o;
  logic [DATA_WIDTH-1:0] mul;
  logic [DATA_WIDTH-1:0] divu;
  logic [DATA_WIDTH-1:0] divs;
  logic [DATA_WIDTH-1:0] rems;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2, raddr3, a, b,
    input  rdata1, rdata2, rdata3, sum, ltu, srl, sra, sll,
           and_o, or_o, xor_o, mul, divu, divs, rems
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2, raddr3, a, b,
    output rdata1, rdata2, rdata3, sum, ltu, srl, sra, sll,
           and_o, or_o, xor_o, mul, divu, divs, rems
  );
endinterface

// File: rtl/rv64_regfile_alu.sv
// RV64 integer core: 32x64 register file (x0 hard-wired to zero) plus combinational ALU.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module rv64_regfile_alu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  rv64_regfile_alu_if.slave   bus
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] regs [NREGS];

  // Entry 0 is a constant, not a flop; only x1..x(NREGS-1) hold state.
  assign regs[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[r] <= '0;
      end else if (bus.wen && (bus.waddr == ADDR_WIDTH'(r))) begin
        regs[r] <= bus.wdata;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  function automatic logic fwd(input logic [ADDR_WIDTH-1:0] ra,
                               input logic [ADDR_WIDTH-1:0] wa,
                               input logic                  we,
                               input logic                  rn);
    return we && rn && (wa != '0) && (ra == wa);
  endfunction

  assign bus.rdata1 = fwd(bus.raddr1, bus.waddr, bus.wen, rst_n) ? bus.wdata : regs[bus.raddr1];
  assign bus.rdata2 = fwd(bus.raddr2, bus.waddr, bus.wen, rst_n) ? bus.wdata : regs[bus.raddr2];
  assign bus.rdata3 = fwd(bus.raddr3, bus.waddr, bus.wen, rst_n) ? bus.wdata : regs[bus.raddr3];
`else
  assign bus.rdata1 = regs[bus.raddr1];
  assign bus.rdata2 = regs[bus.raddr2];
  assign bus.rdata3 = regs[bus.raddr3];
`endif

  logic [SHW-1:0]        shamt;
  logic                  b_zero;
  logic [DATA_WIDTH-1:0] mag_a;
  logic [DATA_WIDTH-1:0] mag_b;
  logic [DATA_WIDTH-1:0] div_b;
  logic [DATA_WIDTH-1:0] div_mag_b;
  logic [DATA_WIDTH-1:0] q_mag;
  logic [DATA_WIDTH-1:0] r_mag;

  assign shamt  = bus.b[SHW-1:0];
  assign b_zero = (bus.b == '0);

  assign bus.sum   = bus.a + bus.b;
  assign bus.ltu   = (bus.b < bus.a);
  assign bus.srl   = bus.a >> shamt;
  assign bus.sra   = DATA_WIDTH'($signed(bus.a) >>> shamt);
  assign bus.sll   = bus.a << shamt;
  assign bus.and_o = bus.a & bus.b;
  assign bus.or_o  = bus.a | bus.b;
  assign bus.xor_o = bus.a ^ bus.b;
  assign bus.mul   = bus.a * bus.b;

  // Divisors are forced non-zero so the dividers never see 0; the zero case is muxed below.
  assign div_b = b_zero ? DATA_WIDTH'(1) : bus.b;
  assign bus.divu = b_zero ? '1 : (bus.a / div_b);

  // Signed divide on magnitudes: the most-negative dividend over -1 yields a 2^63
  // magnitude whose negation wraps back to a, and remainder 0, with no special case.
  assign mag_a     = bus.a[DATA_WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign mag_b     = bus.b[DATA_WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign div_mag_b = b_zero ? DATA_WIDTH'(1) : mag_b;
  assign q_mag     = mag_a / div_mag_b;
  assign r_mag     = mag_a % div_mag_b;

  always_comb begin
    bus.divs = '1;
    bus.rems = bus.a;
    if (!b_zero) begin
      bus.divs = (bus.a[DATA_WIDTH-1] ^ bus.b[DATA_WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
      bus.rems = bus.a[DATA_WIDTH-1] ? (~r_mag + 1'b1) : r_mag;
    end
  end

endmodule

// File: tb/tb_rv64_regfile_alu.sv
// Directed bench for rv64_regfile_alu: reference model of registers and ALU checked every
// negedge, plus hand-computed literal expectations for the key vectors.
module tb_rv64_regfile_alu;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  logic [63:0] model_regs [32];

  always #5 clk = ~clk;

  rv64_regfile_alu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

  rv64_regfile_alu #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk)
    if (rst_n === 1'b1 && bus.wen === 1'b1 && bus.waddr != 5'd0)
      model_regs[bus.waddr] = bus.wdata;

  always @(negedge rst_n)
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;

  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (rst_n !== 1'b1 || ra == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wen === 1'b1 && bus.waddr != 5'd0 && bus.waddr == ra) return bus.wdata;
`endif
    return model_regs[ra];
  endfunction

  function automatic logic [63:0] exp_sra(input logic [63:0] a, input logic [63:0] b);
    int sh = int'(b % 64);
    return (a >> sh) | (a[63] ? ~(ONES >> sh) : 64'd0);
  endfunction

  function automatic logic [63:0] exp_divs(input logic [63:0] a, input logic [63:0] b);
    longint sa = a;
    longint sb = b;
    if (b == 64'd0) return ONES;
    if (a == MINV && b == ONES) return a;
    return 64'(sa / sb);
  endfunction

  function automatic logic [63:0] exp_rems(input logic [63:0] a, input logic [63:0] b);
    longint sa = a;
    longint sb = b;
    if (b == 64'd0) return a;
    if (a == MINV && b == ONES) return 64'd0;
    return 64'(sa % sb);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [63:0] a;
      logic [63:0] b;
      int sh;
      a = bus.a;
      b = bus.b;
      sh = int'(b % 64);
      check64("m_rdata1", bus.rdata1, exp_rd(bus.raddr1));
      check64("m_rdata2", bus.rdata2, exp_rd(bus.raddr2));
      check64("m_rdata3", bus.rdata3, exp_rd(bus.raddr3));
      check64("m_sum", bus.sum, a + b);
      check64("m_ltu", 64'(bus.ltu), (b < a) ? 64'd1 : 64'd0);
      check64("m_srl", bus.srl, a >> sh);
      check64("m_sra", bus.sra, exp_sra(a, b));
      check64("m_sll", bus.sll, a * (64'd1 << sh));
      check64("m_and", bus.and_o, a & b);
      check64("m_or", bus.or_o, a | b);
      check64("m_xor", bus.xor_o, a ^ b);
      check64("m_mul", bus.mul, a * b);
      check64("m_divu", bus.divu, (b == 64'd0) ? ONES : a / b);
      check64("m_divs", bus.divs, exp_divs(a, b));
      check64("m_rems", bus.rems, exp_rems(a, b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
    @(posedge clk); #1;
    bus.wen = 1'b1; bus.waddr = idx; bus.wdata = val;
    @(posedge clk); #1;
    bus.wen = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3);
    bus.raddr1 = r1; bus.raddr2 = r2; bus.raddr3 = r3;
    #1;
  endtask

  task automatic set_alu(input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    bus.a = a; bus.b = b;
    #1;
  endtask

  logic [4:0]  tbl_idx [6] = '{5'd1, 5'd2, 5'd15, 5'd16, 5'd30, 5'd31};
  logic [63:0] tbl_val [6] = '{64'h0000_0000_0000_0001, 64'hDEAD_BEEF_0000_0002,
                               64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
                               64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF};

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    rst_n = 1'b0;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.raddr1 = '0; bus.raddr2 = '0; bus.raddr3 = '0;
    bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // reset state
    set_reads(5'd1, 5'd17, 5'd31);
    check64("rst_x1", bus.rdata1, 64'd0);
    check64("rst_x31", bus.rdata3, 64'd0);

    // asynchronous reset mid-cycle, writes ignored while held
    write_reg(5'd5, 64'h1234);
    set_reads(5'd5, 5'd5, 5'd3);
    check64("x5_written", bus.rdata1, 64'h1234);
    #1 rst_n = 1'b0;
    #1 check64("async_rst_x5", bus.rdata1, 64'd0);
    bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 64'hFF;
    @(posedge clk); #1;
    bus.wen = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      set_reads(5'(i), 5'(i), 5'(i));
      check64("post_rst_zero", bus.rdata1, 64'd0);
    end

    // x0 protection and three-port read
    write_reg(5'd0, ONES);
    set_reads(5'd0, 5'd0, 5'd0);
    check64("x0_read", bus.rdata1, 64'd0);
    write_reg(5'd10, 64'h2A);
    set_reads(5'd10, 5'd10, 5'd10);
    check64("x10_p1", bus.rdata1, 64'h2A);
    check64("x10_p2", bus.rdata2, 64'h2A);
    check64("x10_p3", bus.rdata3, 64'h2A);

    // same-cycle write/read of x7
    write_reg(5'd7, 64'h1);
    bus.wen = 1'b1; bus.waddr = 5'd7; bus.wdata = 64'h2;
    set_reads(5'd7, 5'd7, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check64("x7_before_edge", bus.rdata1, 64'h2);
`else
    check64("x7_before_edge", bus.rdata1, 64'h1);
`endif
    @(posedge clk); #1;
    bus.wen = 1'b0;
    #1 check64("x7_after_edge", bus.rdata2, 64'h2);

    // table of writes, read back across ports
    for (int i = 0; i < 6; i++) write_reg(tbl_idx[i], tbl_val[i]);
    for (int i = 0; i < 6; i += 2) begin
      set_reads(tbl_idx[i], tbl_idx[i+1], tbl_idx[5-i]);
      check64("tbl_p1", bus.rdata1, tbl_val[i]);
      check64("tbl_p2", bus.rdata2, tbl_val[i+1]);
      check64("tbl_p3", bus.rdata3, tbl_val[5-i]);
    end

    // ALU directed vectors
    set_alu(ONES, 64'd1);
    check64("neg1_sum", bus.sum, 64'd0);
    check64("neg1_mul", bus.mul, ONES);
    check64("neg1_ltu", 64'(bus.ltu), 64'd1);
    check64("neg1_srl", bus.srl, 64'h7FFF_FFFF_FFFF_FFFF);
    check64("neg1_sra", bus.sra, ONES);
    check64("neg1_sll", bus.sll, 64'hFFFF_FFFF_FFFF_FFFE);
    set_alu(64'd1, 64'd2);
    check64("ltu_1_2", 64'(bus.ltu), 64'd0);
    set_alu(64'd5, 64'd5);
    check64("ltu_eq", 64'(bus.ltu), 64'd0);
    set_alu(64'd1, 64'd65);
    check64("sll_mask", bus.sll, 64'd2);
    set_alu(64'hF0F0, 64'hFF00);
    check64("and", bus.and_o, 64'hF000);
    check64("or", bus.or_o, 64'hFFF0);
    check64("xor", bus.xor_o, 64'h0FF0);
    set_alu(64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    check64("m7_divs", bus.divs, 64'hFFFF_FFFF_FFFF_FFFD);
    check64("m7_rems", bus.rems, ONES);
    check64("m7_divu", bus.divu, 64'h7FFF_FFFF_FFFF_FFFC);
    set_alu(64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    check64("p7_divs", bus.divs, 64'hFFFF_FFFF_FFFF_FFFD);
    check64("p7_rems", bus.rems, 64'd1);
    set_alu(64'h123, 64'd0);
    check64("dz_divu", bus.divu, ONES);
    check64("dz_divs", bus.divs, ONES);
    check64("dz_rems", bus.rems, 64'h123);
    set_alu(MINV, ONES);
    check64("ovf_divs", bus.divs, MINV);
    check64("ovf_rems", bus.rems, 64'd0);
    set_alu(MINV, 64'd68);
    check64("sra_min_4", bus.sra, 64'hF800_0000_0000_0000);
    set_alu(64'h0000_0001_0000_0003, 64'h0000_0002_0000_0005);
    check64("mul_wide", bus.mul, 64'h0000_000B_0000_000F);
    set_alu(64'd1000, 64'hFFFF_FFFF_FFFF_FFF9);
    check64("sub_via_neg", bus.sum, 64'd993);

    @(posedge clk); #1;
    @(negedge clk); #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
